// File: rtl/serial_addsub4.sv
// rtl/serial_addsub4.sv - bit-serial two's-complement add/sub/abs/negate unit
//
// Purpose: accepts an operand pair over a valid/ready handshake, computes the
// result LSB-first through one full-adder slice and a carry flop (one bit per
// clock), then presents result, carry-out and signed overflow over a
// valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand pair valid
//   in_ready  unit can accept operands (high only when idle)
//   a, b      signed operands; b is ignored for abs/negate
//   op        00 A+B, 01 A-B, 10 |A|, 11 -A
//   out_valid result valid (high while done)
//   out_ready downstream accepts result
//   r         result
//   cout      carry out of the MSB
//   ovf       signed overflow
`timescale 1ns/1ps

module serial_addsub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic            c_q, c_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic            sum_bit;
    logic            carry_next;

    // Single full-adder slice operating on the current LSBs.
    assign sum_bit    = x_q[0] ^ y_q[0] ^ c_q;
    assign carry_next = (x_q[0] & y_q[0]) | ((x_q[0] ^ y_q[0]) & c_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    // Subtraction and negation are X + ~Y + 1; abs only
                    // negates when A is negative, otherwise passes A through.
                    case (op)
                        2'b00: begin
                            x_d = a;
                            y_d = b;
                            c_d = 1'b0;
                        end
                        2'b01: begin
                            x_d = a;
                            y_d = ~b;
                            c_d = 1'b1;
                        end
                        2'b10: begin
                            if (a[WIDTH-1]) begin
                                x_d = '0;
                                y_d = ~a;
                                c_d = 1'b1;
                            end else begin
                                x_d = a;
                                y_d = '0;
                                c_d = 1'b0;
                            end
                        end
                        2'b11: begin
                            x_d = '0;
                            y_d = ~a;
                            c_d = 1'b1;
                        end
                    endcase
                end
            end

            S_CALC: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                r_d   = {sum_bit, r_q[WIDTH-1:1]};
                c_d   = carry_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // c_q here is the carry into the MSB.
                    ovf_d   = c_q ^ carry_next;
                    cout_d  = carry_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign r         = r_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub4.sv
// tb/tb_serial_addsub4.sv - self-checking bench for serial_addsub4
`timescale 1ns/1ps

module tb_serial_addsub4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {cout, ovf, r}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [1:0] mop);
        int sa, sb, ua, ub, res, maxv, minv;
        logic [W-1:0] rv;
        logic c, o;
        sa   = $signed(ma);
        sb   = $signed(mb);
        ua   = int'(ma);
        ub   = int'(mb);
        maxv = (1 << (W - 1)) - 1;
        minv = -(1 << (W - 1));
        c    = 1'b0;
        case (mop)
            2'b00: begin res = sa + sb; c = ((ua + ub) >= (1 << W)); end
            2'b01: begin res = sa - sb; c = (ua >= ub); end
            2'b10: begin res = (sa < 0) ? -sa : sa; c = 1'b0; end
            default: begin res = -sa; c = (ua == 0); end
        endcase
        o  = (res > maxv) || (res < minv);
        rv = res[W-1:0];
        return {c, o, rv};
    endfunction

    // Cycle-level expectation: idle -> W compute cycles -> done until out_ready.
    int m_phase = 0;
    int m_left  = 0;
    logic [W+1:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {27'd0, in_ready, out_valid, r, cout, ovf},
                {27'd0, 1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0});
            exp_q.delete();
            m_phase = 0;
            m_left  = 0;
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin
                    chk("result", {cout, ovf, r}, exp_q[0]);
                end
            end
            case (m_phase)
                0: if (in_valid) begin
                    exp_q.push_back(model(a, b, op));
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) begin
                    void'(exp_q.pop_front());
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic wait_out_valid(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                          input int hold, output logic [W-1:0] rr, output logic rc,
                          output logic ro);
        int guard;
        @(posedge clk);
        #1;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        wait_out_valid("run_op");
        rr = r; rc = cout; ro = ovf;
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic [W-1:0] rr, r0;
        logic rc, ro;
        logic [W+1:0] m;

        vecs.push_back('{2'b00, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0});
        vecs.push_back('{2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{2'b01, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1});
        vecs.push_back('{2'b01, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{2'b10, 4'b1011, 4'b1111, 4'b0101, 1'b0, 1'b0});
        vecs.push_back('{2'b10, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{2'b11, 4'b0000, 4'b1010, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{2'b11, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1});
        vecs.push_back('{2'b10, 4'b0110, 4'b1001, 4'b0110, 1'b0, 1'b0});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, each also pinning the reference model.
        foreach (vecs[i]) begin
            m = model(vecs[i].a, vecs[i].b, vecs[i].op);
            chk($sformatf("model_pin_%0d", i), m, {vecs[i].c, vecs[i].o, vecs[i].r});
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, i % 3, rr, rc, ro);
            chk($sformatf("directed_%0d", i), {rc, ro, rr}, {vecs[i].c, vecs[i].o, vecs[i].r});
        end

        // Backpressure: result must hold and new operands wait.
        @(posedge clk);
        #1 a = 4'b0110; b = 4'b0001; op = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 4'b0010; b = 4'b0011; op = 2'b00;
        wait_out_valid("bp_first");
        r0 = r;
        chk("bp_first_r", r0, 4'b0101);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_r_stable", r, r0);
            chk("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out_valid("bp_second");
        chk("bp_second_r", {cout, ovf, r}, {1'b0, 1'b0, 4'b0101});
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset during the second compute cycle.
        @(posedge clk);
        #1 a = 4'b1111; b = 4'b1111; op = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset", {in_ready, out_valid, r}, {1'b1, 1'b0, 4'b0000});
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(4'b0001, 4'b0001, 2'b00, 0, rr, rc, ro);
        chk("post_reset", {rc, ro, rr}, {1'b0, 1'b0, 4'b0010});

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(W'($urandom), W'($urandom), 2'($urandom), $urandom_range(0, 3), rr, rc, ro);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub4.md
Name: serial_addsub4

Overview:
- Bit-serial 4-bit two's-complement add/subtract/abs/negate unit.
- Sits directly upstream of the result-display stage. It accepts operand pairs over a valid/ready handshake and computes LSB-first through a single full-adder slice plus a carry flop, one bit per clock.
- Presents the registered result, carry-out and signed-overflow flag over a valid/ready handshake.
- Replaces the parallel ripple adder / absolute-value path where area matters.

Parameters:
- WIDTH, 4, operand/result width in bits (two's complement); must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  operand A (signed).
- b  input  WIDTH  operand B (signed); ignored for op 10/11.
- op  input  2  00 A+B, 01 A-B, 10 |A|, 11 -A.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- r  output  WIDTH  result.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n), on clk rising edge domain.
- Reset values: state=IDLE; r=0, cout=0, ovf=0, out_valid=0; carry flop=0; bit counter=0. in_ready=1 while in reset, since it decodes IDLE.
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid&in_ready, latch the operands into shift registers X and Y, set counter=0, set carry flop=cin, and go to CALC.
  - Operand mapping:
    - 00: X=a, Y=b, cin=0.
    - 01: X=a, Y=~b, cin=1.
    - 10 with a[MSB]=1: X=0, Y=~a, cin=1.
    - 10 with a[MSB]=0: X=a, Y=0, cin=0.
    - 11: X=0, Y=~a, cin=1.
- CALC, exactly WIDTH cycles:
  - Each cycle: s = X[0]^Y[0]^c; c_next = X[0]&Y[0] | (X[0]^Y[0])&c.
  - Shift s into the MSB of the result shift register; shift X and Y right; counter++.
  - On the cycle with counter==WIDTH-1:
    - Capture ovf = c (carry into MSB) ^ c_next.
    - Capture cout = c_next.
    - Go to DONE.
- DONE:
  - r, cout and ovf are held stable while out_valid=1.
  - On out_ready go to IDLE.
  - out_ready is ignored in all other states.
- Latency: handshake at edge N gives out_valid high after edge N+WIDTH; WIDTH+1 cycles until in_ready again at best.
  - No pipelining; back-to-back throughput is one op per WIDTH+2 cycles.
- Inputs a/b/op may change freely outside the accepting cycle; only captured values are used.
- Boundary results:
  - |MIN| and -MIN (1000 for WIDTH=4) return 1000 with ovf=1.
  - -0 returns 0000 with cout=1, ovf=0.
- Stalled output: out_ready low holds DONE indefinitely; no new operands are accepted.
- Reset mid-operation (CALC or DONE): immediately returns to reset values. The partial result is discarded and no out_valid pulse is produced.
- in_valid asserted in CALC/DONE: not accepted (in_ready=0). The upstream must hold it.

Test Plan:
- Reset, then op=00 a=0011 b=0100 -> after 4 CALC cycles r=0111, cout=0, ovf=0, out_valid held until out_ready.
- op=00 a=0111 b=0001 -> r=1000, ovf=1, cout=0. op=00 a=1111 b=0001 -> r=0000, cout=1, ovf=0.
- op=01 a=1000 b=0001 -> r=0111, ovf=1. op=01 a=0101 b=0101 -> r=0000, cout=1, ovf=0.
- op=10 a=1011 -> r=0101, ovf=0. op=10 a=1000 -> r=1000, ovf=1. op=11 a=0000 -> r=0000, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands -> r stable, in_ready=0, second op accepted only on the cycle after out_ready=1.
- Assert rst_n=0 during the 2nd CALC cycle -> out_valid=0, r=0, in_ready=1 immediately. The next op then computes correctly with no residual carry.
